// File: rtl/uart_dump_pkg.sv
// Shared state encoding, defaults and round-robin helper for the UART dump scheduler.
// The FAULT state exists only when UART_DUMP_WDOG_EN is defined.
package uart_dump_pkg;

    localparam int AW_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
`ifdef UART_DUMP_WDOG_EN
        ,
        ST_FAULT
`endif
    } state_e;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr, cyclic.
// The pointer itself is owned by the caller.
module uart_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt_oh,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any_req
);

    localparam int IW = $clog2(N_REQ);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_req && req[(int'(ptr) + k) % N_REQ]) begin
                any_req                            = 1'b1;
                gnt_oh[(int'(ptr) + k) % N_REQ]    = 1'b1;
                gnt_idx                            = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_dump_scheduler.sv
// Round-robin scheduler sharing one UART memory-dump engine between N_REQ requesters.
// Define UART_DUMP_WDOG_EN to add the RUN watchdog, req_err pulses and the FAULT state.
module uart_dump_scheduler
    import uart_dump_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int AW          = AW_DEFAULT,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*AW-1:0]      req_start_addr,
    input  logic [N_REQ*AW-1:0]      req_stop_addr,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_err,
    output logic                     ctl_start,
    output logic [AW-1:0]            ctl_start_addr,
    output logic [AW-1:0]            ctl_stop_addr,
    input  logic                     ctl_work,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
        $error("uart_dump_scheduler: N_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     slot_full_q, slot_full_d;
    logic [AW-1:0]        slot_start_q [N_REQ];
    logic [AW-1:0]        slot_start_d [N_REQ];
    logic [AW-1:0]        slot_stop_q  [N_REQ];
    logic [AW-1:0]        slot_stop_d  [N_REQ];
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic [N_REQ-1:0]     grant_oh_q, grant_oh_d;
    logic                 ctl_start_q, ctl_start_d;
    logic [AW-1:0]        ctl_start_addr_q, ctl_start_addr_d;
    logic [AW-1:0]        ctl_stop_addr_q, ctl_stop_addr_d;
    logic                 busy_q, busy_d;
    logic [N_REQ-1:0]     req_done_q, req_done_d;
    logic [N_REQ-1:0]     slot_clr;
    logic [N_REQ-1:0]     capture;
    logic [N_REQ-1:0]     arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;

`ifdef UART_DUMP_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0]        wdog_q, wdog_d;
    logic [N_REQ-1:0]     req_err_q, req_err_d;
    assign slot_clr = req_done_q | req_err_q;
    assign req_err  = req_err_q;
`else
    assign slot_clr = req_done_q;
    assign req_err  = '0;
`endif

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (slot_full_q),
        .ptr     (rr_ptr_q),
        .gnt_oh  (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    assign capture = req_valid & ~slot_full_q;

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_id_d       = grant_id_q;
        grant_oh_d       = grant_oh_q;
        ctl_start_d      = 1'b0;
        ctl_start_addr_d = ctl_start_addr_q;
        ctl_stop_addr_d  = ctl_stop_addr_q;
        busy_d           = busy_q;
        req_done_d       = '0;
`ifdef UART_DUMP_WDOG_EN
        wdog_d           = wdog_q;
        req_err_d        = '0;
`endif

        // A slot frees the cycle after its done/err pulse, so req_ready rises one cycle later.
        slot_full_d = (slot_full_q & ~slot_clr) | capture;
        if (|slot_clr) begin
            rr_ptr_d = IW'(rr_next(32'(grant_id_q), N_REQ));
        end
        for (int i = 0; i < N_REQ; i++) begin
            slot_start_d[i] = slot_start_q[i];
            slot_stop_d[i]  = slot_stop_q[i];
            if (capture[i]) begin
                slot_start_d[i] = req_start_addr[i*AW +: AW];
                slot_stop_d[i]  = req_stop_addr[i*AW +: AW];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_id_d       = arb_idx;
                    grant_oh_d       = arb_gnt;
                    ctl_start_addr_d = slot_start_q[arb_idx];
                    ctl_stop_addr_d  = slot_stop_q[arb_idx];
                    ctl_start_d      = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
`ifdef UART_DUMP_WDOG_EN
                wdog_d  = '0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctl_work) begin
                    req_done_d = grant_oh_q;
                    busy_d     = 1'b0;
                    state_d    = ST_DONE;
                end
`ifdef UART_DUMP_WDOG_EN
                else if (wdog_q == CW'(WDOG_CYCLES - 1)) begin
                    req_err_d = grant_oh_q;
                    state_d   = ST_FAULT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
`ifdef UART_DUMP_WDOG_EN
            // The engine is still driving its master; wait for it to let go before reusing it.
            ST_FAULT: begin
                if (!ctl_work) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            slot_full_q      <= '0;
            rr_ptr_q         <= '0;
            grant_id_q       <= '0;
            grant_oh_q       <= '0;
            ctl_start_q      <= 1'b0;
            ctl_start_addr_q <= '0;
            ctl_stop_addr_q  <= '0;
            busy_q           <= 1'b0;
            req_done_q       <= '0;
`ifdef UART_DUMP_WDOG_EN
            wdog_q           <= '0;
            req_err_q        <= '0;
`endif
        end else begin
            state_q          <= state_d;
            slot_full_q      <= slot_full_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_id_q       <= grant_id_d;
            grant_oh_q       <= grant_oh_d;
            ctl_start_q      <= ctl_start_d;
            ctl_start_addr_q <= ctl_start_addr_d;
            ctl_stop_addr_q  <= ctl_stop_addr_d;
            busy_q           <= busy_d;
            req_done_q       <= req_done_d;
`ifdef UART_DUMP_WDOG_EN
            wdog_q           <= wdog_d;
            req_err_q        <= req_err_d;
`endif
        end
    end

    // NOTE: slot addresses are payload qualified by slot_full_q, so they carry no reset.
    always_ff @(posedge clk) begin
        slot_start_q <= slot_start_d;
        slot_stop_q  <= slot_stop_d;
    end

    assign req_ready      = ~slot_full_q;
    assign req_done       = req_done_q;
    assign ctl_start      = ctl_start_q;
    assign ctl_start_addr = ctl_start_addr_q;
    assign ctl_stop_addr  = ctl_stop_addr_q;
    assign busy           = busy_q;
    assign grant_id       = grant_id_q;

endmodule

// File: tb/tb_uart_dump_scheduler.sv
// Scoreboard bench for uart_dump_scheduler with a simple dump-engine model.
// Define UART_DUMP_WDOG_EN (for bench and RTL) to add the watchdog scenario.
module tb_uart_dump_scheduler;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] s;
        logic [AW-1:0] e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_start_addr = '0;
    logic [N*AW-1:0]   req_stop_addr = '0;
    logic [N-1:0]      req_ready, req_done, req_err;
    logic              ctl_start, ctl_work, busy;
    logic [AW-1:0]     ctl_start_addr, ctl_stop_addr;
    logic [IW-1:0]     grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_dones  = 0;
    int n_errs   = 0;
    int done_cnt [N];
    exp_t exp_q [$];
    logic active = 1'b0;
    logic [IW-1:0] act_id = '0;

    // Engine model: work is high from the start cycle for eng_len cycles, or forever while hung.
    int         eng_len  = 40;
    logic       eng_hang = 1'b0;
    logic [7:0] eng_rem;
    assign ctl_work = ctl_start | (eng_rem != 8'd0) | eng_hang;
    always @(posedge clk or posedge rst) begin
        if (rst)                   eng_rem <= 8'd0;
        else if (ctl_start)        eng_rem <= 8'(eng_len - 1);
        else if (eng_rem != 8'd0)  eng_rem <= eng_rem - 8'd1;
    end

    always #5 clk = ~clk;

    uart_dump_scheduler #(.N_REQ(N), .AW(AW), .WDOG_CYCLES(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_start_addr (req_start_addr),
        .req_stop_addr  (req_stop_addr),
        .req_ready      (req_ready),
        .req_done       (req_done),
        .req_err        (req_err),
        .ctl_start      (ctl_start),
        .ctl_start_addr (ctl_start_addr),
        .ctl_stop_addr  (ctl_stop_addr),
        .ctl_work       (ctl_work),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input int id, input int s, input int e);
        exp_t x;
        x.id = IW'(id);
        x.s  = AW'(s);
        x.e  = AW'(e);
        return x;
    endfunction

    // Load requester id's window and queue the grant it should produce.
    task automatic arm(input int id, input int s, input int e);
        req_start_addr[id*AW +: AW] = AW'(s);
        req_stop_addr[id*AW +: AW]  = AW'(e);
        exp_q.push_back(mk(id, s, e));
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        @(negedge clk);
        req_valid = mask;
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic post_when_ready(input int id);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready[id] && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", req_ready[id], 1'b1);
        req_valid[id] = 1'b1;
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, req_ready, {N{1'b1}});
        check({tag, "_done"}, req_done, '0);
        check({tag, "_err"}, req_err, '0);
        check({tag, "_start"}, ctl_start, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_gid"}, grant_id, '0);
        check({tag, "_saddr"}, ctl_start_addr, '0);
        check({tag, "_eaddr"}, ctl_stop_addr, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        eng_hang = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (t < budget && !(exp_q.size() == 0 && !active && !busy)) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", (t < budget), 1'b1);
    endtask

    task automatic wait_start(input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while (t < budget && !ctl_start) begin
            @(negedge clk);
            t++;
        end
        check("start_timeout", ctl_start, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every start and checks each completion.
    initial begin
        exp_t e;
        logic rdy_pend;
        logic [IW-1:0] rdy_id;
        logic work_d1, work_d2;
        rdy_pend = 1'b0;
        rdy_id   = '0;
        work_d1  = 1'b0;
        work_d2  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active   = 1'b0;
                rdy_pend = 1'b0;
                work_d1  = 1'b0;
                work_d2  = 1'b0;
            end else begin
                if (rdy_pend) begin
                    check("ready_after_end", req_ready[rdy_id], 1'b1);
                    rdy_pend = 1'b0;
                end
                if (ctl_start) begin
                    n_starts++;
                    check("start_while_active", active, 1'b0);
                    check("busy_at_start", busy, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("start_expected", 1'b0, 1'b1);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", grant_id, e.id);
                        check("start_addr", ctl_start_addr, e.s);
                        check("stop_addr", ctl_stop_addr, e.e);
                        act_id = e.id;
                    end
                    active = 1'b1;
                end
                if (req_done != '0) begin
                    n_dones++;
                    done_cnt[act_id]++;
                    check("done_vec", req_done, oh(act_id));
                    check("done_active", active, 1'b1);
                    check("done_after_work_fall", {work_d2, work_d1}, 2'b10);
                    check("ready_low_at_done", req_ready[act_id], 1'b0);
                    active   = 1'b0;
                    rdy_pend = 1'b1;
                    rdy_id   = act_id;
                end
                if (req_err != '0) begin
                    n_errs++;
                    check("err_vec", req_err, oh(act_id));
                    active   = 1'b0;
                    rdy_pend = 1'b1;
                    rdy_id   = act_id;
                end
                work_d2 = work_d1;
                work_d1 = ctl_work;
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0, d0, exp_errs;
        logic seen;
        exp_errs = 0;

        // 1: single request, latency and one-byte-after-fall completion
        do_reset();
        eng_len = 40;
        arm(0, 'h0010, 'h0013);
        pulse(4'b0001);
        check("t1_ready_drop", req_ready[0], 1'b0);
        check("t1_no_early_start", ctl_start, 1'b0);
        @(negedge clk);
        check("t1_start_latency", ctl_start, 1'b1);
        s0 = n_starts;
        wait_idle(200);
        check("t1_done_count", done_cnt[0], 1);

        // 2: all requesters at once, served 0..3 one at a time
        do_reset();
        eng_len = 12;
        s0 = n_starts;
        arm(0, 'h0100, 'h0107);
        arm(1, 'h0200, 'h02FF);
        arm(2, 'h3000, 'h3001);
        arm(3, 'h4444, 'h4450);
        pulse(4'b1111);
        check("t2_ready_all_low", req_ready, 4'b0000);
        wait_idle(400);
        check("t2_start_count", n_starts - s0, 4);
        for (int i = 0; i < N; i++) check("t2_done_each", done_cnt[i], 1);

        // 3: requester 0 re-requests while 2 waits -> 0,2,0
        do_reset();
        eng_len = 10;
        arm(0, 'h0A00, 'h0A03);
        pulse(4'b0001);
        repeat (3) @(negedge clk);
        arm(2, 'h0C00, 'h0C10);
        pulse(4'b0100);
        req_start_addr[0*AW +: AW] = 16'h0B00;
        req_stop_addr[0*AW +: AW]  = 16'h0B07;
        exp_q.push_back(mk(0, 'h0B00, 'h0B07));
        post_when_ready(0);
        wait_idle(400);
        check("t3_done0", done_cnt[0], 2);
        check("t3_done2", done_cnt[2], 1);

        // 4: edge windows forwarded untouched
        do_reset();
        eng_len = 3;
        arm(1, 'hFFFF, 'hFFFF);
        arm(3, 'hFFFE, 'h0001);
        pulse(4'b1010);
        wait_idle(200);
        check("t4_done1", done_cnt[1], 1);
        check("t4_done3", done_cnt[3], 1);

        // 5: reset while running with another slot pending
        do_reset();
        eng_len = 40;
        arm(2, 'h1234, 'h1300);
        req_start_addr[3*AW +: AW] = 16'h5555;
        req_stop_addr[3*AW +: AW]  = 16'h5566;
        pulse(4'b1100);
        wait_start(50);
        repeat (5) @(negedge clk);
        check("t5_busy_in_run", busy, 1'b1);
        check("t5_gid_in_run", grant_id, 2'd2);
        #1 rst = 1'b1;
        #1 check_reset_vals("t5_async");
        exp_q.delete();
        s0 = n_starts;
        d0 = n_dones;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t5_no_start", n_starts - s0, 0);
        check("t5_no_done", n_dones - d0, 0);
        check("t5_slots_empty", req_ready, 4'b1111);

`ifdef UART_DUMP_WDOG_EN
        // 6: hung engine trips the watchdog, then the next slot is served
        do_reset();
        eng_len  = 4;
        eng_hang = 1'b1;
        arm(0, 'h0100, 'h01FF);
        arm(1, 'h0200, 'h020F);
        pulse(4'b0011);
        wait_start(50);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | (|req_err);
        end
        check("t6_err_early", seen, 1'b0);
        @(negedge clk);
        check("t6_err_pulse", req_err, 4'b0001);
        check("t6_no_done", req_done, 4'b0000);
        check("t6_busy_fault", busy, 1'b1);
        s0 = n_starts;
        repeat (20) @(negedge clk);
        check("t6_busy_held", busy, 1'b1);
        check("t6_no_start_in_fault", n_starts - s0, 0);
        check("t6_slot0_freed", req_ready[0], 1'b1);
        eng_hang = 1'b0;
        wait_idle(200);
        check("t6_done0", done_cnt[0], 0);
        check("t6_done1", done_cnt[1], 1);
        exp_errs = 1;
`endif

        repeat (3) @(negedge clk);
        check("err_total", n_errs, exp_errs);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
